frame_sequencer: RTL and testbench

//   Divides the system clock to the 512 Hz frame rate and runs the 8-step frame schedule.

---
 rtl/frame_sequencer.sv | 80 ++++++++
 tb/tb_frame_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// Frame sequencer: divides clk to the frame-step rate and runs the 8-step L/S/E schedule.
// Define FS_EXT_TICK_EN to drop the prescaler and step on the external tickExt input.
module frame_sequencer #(
   parameter int unsigned DIVISOR = 8192
) (
   input  logic       clk,
   input  logic       rstN,
   input  logic       enable,
   input  logic       divReset,
`ifdef FS_EXT_TICK_EN
   input  logic       tickExt,
`endif
   output logic       frameTick,
   output logic       lengthTick,
   output logic       sweepTick,
   output logic       envTick,
   output logic [2:0] step
);

   if (DIVISOR < 2) begin : g_divisor_check
      $error("frame_sequencer: DIVISOR must be >= 2");
   end

   logic       tick;
   logic [2:0] step_q;
   logic       frame_q;
   logic       length_q;
   logic       sweep_q;
   logic       env_q;

`ifdef FS_EXT_TICK_EN
   logic unused_div_reset;
   assign unused_div_reset = divReset;
   assign tick             = enable & tickExt;
`else
   localparam int unsigned PW = $clog2(DIVISOR);
   localparam logic [PW-1:0] Reload = PW'(DIVISOR - 1);

   logic [PW-1:0] presc_q;

   // A divider write in the terminal cycle wins: that tick is lost.
   assign tick = enable & ~divReset & (presc_q == '0);

   always_ff @(posedge clk) begin
      if (!rstN) begin
         presc_q <= Reload;
      end else if (!enable || divReset || (presc_q == '0)) begin
         presc_q <= Reload;
      end else begin
         presc_q <= presc_q - 1'b1;
      end
   end
`endif

   // Pulses are decoded from the step being executed, one cycle after its tick.
   always_ff @(posedge clk) begin
      if (!rstN || !enable) begin
         step_q   <= 3'd0;
         frame_q  <= 1'b0;
         length_q <= 1'b0;
         sweep_q  <= 1'b0;
         env_q    <= 1'b0;
      end else begin
         frame_q  <= tick;
         length_q <= tick & ~step_q[0];
         sweep_q  <= tick & (step_q[1:0] == 2'b10);
         env_q    <= tick & (step_q == 3'd7);
         if (tick) begin
            step_q <= step_q + 3'd1;
         end
      end
   end

   assign frameTick  = frame_q;
   assign lengthTick = length_q;
   assign sweepTick  = sweep_q;
   assign envTick    = env_q;
   assign step       = step_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed self-checking bench for frame_sequencer: small-divisor schedule, divider write,
// enable drop, mid-pulse reset, and step/period spacing at the default divisor.
module tb_frame_sequencer;

   logic       clk;
   logic       rstN;
   logic       enable;
   logic       divReset;
   logic       frameTick;
   logic       lengthTick;
   logic       sweepTick;
   logic       envTick;
   logic [2:0] step;

   logic       rst2N;
   logic       en2;
   logic       div2;
   logic       frame2;
   logic       length2;
   logic       sweep2;
   logic       env2;
   logic [2:0] step2;

   int n_checks;
   int n_fail;

   // Schedule {L,S,E} per executed step.
   logic [2:0] lut [8];

   frame_sequencer #(
      .DIVISOR(4)
   ) dut (
      .clk       (clk),
      .rstN      (rstN),
      .enable    (enable),
      .divReset  (divReset),
      .frameTick (frameTick),
      .lengthTick(lengthTick),
      .sweepTick (sweepTick),
      .envTick   (envTick),
      .step      (step)
   );

   frame_sequencer dut2 (
      .clk       (clk),
      .rstN      (rst2N),
      .enable    (en2),
      .divReset  (div2),
      .frameTick (frame2),
      .lengthTick(length2),
      .sweepTick (sweep2),
      .envTick   (env2),
      .step      (step2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick_clk();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [6:0] outs();
      return {frameTick, lengthTick, sweepTick, envTick, step};
   endfunction

   // Cycle n after release (DIVISOR=4): pulses at n%4==0, step = (n/4)%8.
   task automatic check_schedule(input string tag, input int ncyc);
      logic [6:0] e;
      int         k;
      for (int n = 1; n <= ncyc; n++) begin
         tick_clk();
         e = '0;
         e[2:0] = 3'((n / 4) % 8);
         if (n % 4 == 0) begin
            k      = (n / 4 - 1) % 8;
            e[6]   = 1'b1;
            e[5:3] = lut[k];
         end
         check_eq($sformatf("%s c%0d", tag, n), 32'(outs()), 32'(e));
      end
   endtask

   initial begin
      int         t_f [3];
      int         t_l [2];
      int         t_s;
      int         nf;
      int         nl;
      logic [6:0] e;
      int         k;

      lut[0] = 3'b100; lut[1] = 3'b000; lut[2] = 3'b110; lut[3] = 3'b000;
      lut[4] = 3'b100; lut[5] = 3'b000; lut[6] = 3'b110; lut[7] = 3'b001;
      n_checks = 0;
      n_fail   = 0;
      rstN     = 1'b0;
      enable   = 1'b0;
      divReset = 1'b0;
      rst2N    = 1'b0;
      en2      = 1'b0;
      div2     = 1'b0;

      repeat (3) tick_clk();
      check_eq("reset_state", 32'(outs()), 32'd0);
      enable = 1'b1;
      repeat (6) tick_clk();
      check_eq("reset_dominates_enable", 32'(outs()), 32'd0);

      // Test 1: release; this cycle is cycle 0.
      rstN = 1'b1;
      check_eq("sched c0", 32'(outs()), 32'd0);
      check_schedule("sched", 64);

      // Test 2: cycle 64 now; prescaler hits 0 in cycle 67.
      repeat (3) tick_clk();
      divReset = 1'b1;
      tick_clk();
      divReset = 1'b0;
      check_eq("divrst c68", 32'(outs()), 32'd0);
      for (int n = 69; n <= 71; n++) begin
         tick_clk();
         check_eq($sformatf("divrst c%0d", n), 32'(outs()), 32'd0);
      end
      tick_clk();
      check_eq("divrst c72", 32'(outs()), 32'({1'b1, 3'b100, 3'd1}));

      // Test 3: run to step 5 (cycle 88), then drop enable.
      for (int n = 73; n <= 88; n++) begin
         tick_clk();
         k      = (n - 72) / 4;
         e      = '0;
         e[2:0] = 3'(1 + k);
         if ((n - 72) % 4 == 0) begin
            e[6]   = 1'b1;
            e[5:3] = lut[k];
         end
         check_eq($sformatf("run c%0d", n), 32'(outs()), 32'(e));
      end
      enable = 1'b0;
      for (int n = 89; n <= 91; n++) begin
         tick_clk();
         check_eq($sformatf("disabled c%0d", n), 32'(outs()), 32'd0);
      end
      enable = 1'b1;
      for (int n = 92; n <= 94; n++) begin
         tick_clk();
         check_eq($sformatf("reenable c%0d", n), 32'(outs()), 32'd0);
      end
      tick_clk();
      check_eq("reenable c95", 32'(outs()), 32'({1'b1, 3'b100, 3'd1}));

      // Test 4: reset while lengthTick is high.
      rstN = 1'b0;
      tick_clk();
      check_eq("midpulse_reset", 32'(outs()), 32'd0);
      rstN = 1'b1;
      check_schedule("restart", 32);

      // Test 5: default divisor.
      rst2N = 1'b1;
      en2   = 1'b1;
      nf    = 0;
      nl    = 0;
      t_s   = 0;
      foreach (t_f[i]) t_f[i] = 0;
      foreach (t_l[i]) t_l[i] = 0;
      for (int n = 1; n <= 24580; n++) begin
         tick_clk();
         if (frame2 && nf < 3) begin
            t_f[nf] = n;
            nf++;
         end
         if (length2 && nl < 2) begin
            t_l[nl] = n;
            nl++;
         end
         if (sweep2 && t_s == 0) t_s = n;
      end
      check_eq("div8192 first_frame", 32'(t_f[0]), 32'd8192);
      check_eq("div8192 frame_spacing", 32'(t_f[1] - t_f[0]), 32'd8192);
      check_eq("div8192 frame_spacing2", 32'(t_f[2] - t_f[1]), 32'd8192);
      check_eq("div8192 first_length", 32'(t_l[0]), 32'd8192);
      check_eq("div8192 length_spacing", 32'(t_l[1] - t_l[0]), 32'd16384);
      check_eq("div8192 first_sweep", 32'(t_s), 32'd24576);
      check_eq("div8192 step", 32'(step2), 32'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
